xadc_drp_responder: RTL
=======================

XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from den_in accept to drdy_out pulse, legal range 1..15.
REQ-002 SHALL have parameter CONV_PERIOD, default 26: cycles between eoc_out pulses, legal range 2..1023.
REQ-003 SHALL have parameter CHAN_ADDR, default 7'h1E: DRP address of the sample register.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port den_in, input, 1: DRP enable, one-cycle request strobe.
REQ-007 SHALL have port dwe_in, input, 1: write enable, qualified by den_in.
REQ-008 SHALL have port daddr_in, input, 7: register address, sampled with den_in.
REQ-009 SHALL have port di_in, input, 16: write data, sampled with den_in.
REQ-010 SHALL have port do_out, output, 16: read data, valid only while drdy_out=1.
REQ-011 SHALL have port drdy_out, output, 1: one-cycle completion pulse for every accepted request.
REQ-012 SHALL have port eoc_out, output, 1: one-cycle end-of-conversion pulse.
REQ-013 SHALL have port sample_in, input, 12: unsigned converter sample.
REQ-014 SHALL have port overrun, output, 1: sticky flag for a den_in received while busy.

Function
REQ-015 SHALL use the states IDLE, BUSY and RESP.
REQ-016 IDLE SHALL go to BUSY when den_in=1, latching daddr_in, dwe_in and di_in, and loading the latency counter with LATENCY-1.
REQ-017 BUSY SHALL decrement the counter each cycle and go to RESP in the cycle after the counter reaches 0.
REQ-018 RESP SHALL assert drdy_out for exactly one cycle, then return to IDLE; den_in in that RESP cycle SHALL be ignored.
REQ-019 Total latency SHALL be exactly LATENCY+1 cycles from the den_in edge to the drdy_out edge.
REQ-020 A den_in received in BUSY or RESP SHALL be dropped, SHALL NOT alter latched fields, and SHALL set overrun until reset.
REQ-021 A read of CHAN_ADDR SHALL return {sample_reg, 4'h0}, with the sample left-justified.
REQ-022 Address 7'h40 (CFG0) SHALL be read/write and 16 bits wide; a write SHALL take effect in the RESP cycle.
REQ-023 Reads of any other address SHALL return 16'h0000, and writes to them SHALL be discarded; drdy_out SHALL still pulse.
REQ-024 A write transaction SHALL drive do_out to 16'h0000 during its drdy_out cycle.
REQ-025 do_out SHALL be 16'h0000 whenever drdy_out=0.
REQ-026 The conversion counter SHALL count 0..CONV_PERIOD-1 and wrap; eoc_out SHALL be 1 when it equals CONV_PERIOD-1.
REQ-027 sample_reg SHALL update from the sample path in the same cycle as eoc_out=1.
REQ-028 When eoc_out and an in-flight read of CHAN_ADDR coincide, the read SHALL return the value captured at accept time, not the new sample.
REQ-029 The conversion counter SHALL run independently of the DRP FSM.
REQ-030 If den_in=1 in the same cycle as eoc_out=1 in IDLE, the request SHALL be accepted normally.

Reset
REQ-031 While rst=1, the FSM SHALL be IDLE, and the conversion counter, latency counter, sample_reg and CFG0 SHALL be 0.
REQ-032 While rst=1, do_out SHALL be 16'h0000, and drdy_out, eoc_out and overrun SHALL be 0.
REQ-033 rst asserted mid-transaction SHALL abort it with no drdy_out pulse; the first eoc_out after reset release SHALL occur CONV_PERIOD cycles later.

Configuration
REQ-034 With DRP_RESP_AVG_EN defined, sample_reg SHALL receive the mean of the last 4 sample_in values (14-bit sum >> 2, truncating).
REQ-035 With DRP_RESP_AVG_EN defined, the 4 values SHALL be taken one per eoc_out, and the history SHALL clear on reset.
REQ-036 Without DRP_RESP_AVG_EN, sample_reg SHALL receive sample_in directly, and no averaging storage SHALL exist.

Structure
REQ-037 Package drp_resp_pkg SHALL hold the FSM state enum, the CFG0 address constant 7'h40 and the 16-bit DRP data width constant.
REQ-038 The eoc_out timing and capture SHALL live in sub-module drp_eoc_timer (conversion counter, plus averaging when enabled).

Verification
REQ-039 With sample_in=12'hABC, CONV_PERIOD elapsed and a read of 7'h1E, do_out SHALL be 16'hABC0 and drdy_out SHALL rise 5 cycles after den_in.
REQ-040 A write of 16'h1234 to 7'h40 followed by a read of 7'h40 SHALL return 16'h1234; a read of 7'h41 SHALL return 16'h0000 with a drdy_out pulse.
REQ-041 A den_in 2 cycles after an accepted den_in SHALL produce a single drdy_out pulse and overrun=1.
REQ-042 rst asserted 2 cycles after den_in SHALL produce no drdy_out, with all outputs 0 the next cycle.
REQ-043 With DRP_RESP_AVG_EN defined, samples 100, 200, 300 and 401 over 4 eoc_out pulses SHALL read back as 250 << 4.
REQ-044 With CONV_PERIOD=26, eoc_out SHALL pulse on cycles 25, 51 and 77 after reset release, each exactly 1 cycle wide.

Source files
------------

// File: rtl/drp_resp_pkg.sv
// Shared definitions for the XADC-style DRP responder: FSM state
// encoding, the CFG0 register address and the DRP data width.
package drp_resp_pkg;

  localparam int          DATA_W    = 16;
  localparam logic [6:0]  CFG0_ADDR = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } drp_state_e;

endpackage

// File: rtl/drp_eoc_timer.sv
// Free-running conversion timer: pulses eoc_out once every CONV_PERIOD
// cycles and captures the converter sample into sample_reg on that pulse.
// Optional feature macro: DRP_RESP_AVG_EN -- when defined, sample_reg
// holds the truncated mean of the last four captured samples.
module drp_eoc_timer #(
  parameter int CONV_PERIOD = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_in,
  output logic        eoc_out,
  output logic [11:0] sample_reg
);

  localparam int             CNT_W = (CONV_PERIOD > 2) ? $clog2(CONV_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CONV_PERIOD - 1);

  logic [CNT_W-1:0] conv_cnt;

  assign eoc_out = (conv_cnt == LAST);

  // Conversion counter: 0..CONV_PERIOD-1, wrapping, independent of DRP traffic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, regardless of statement order.
    if (rst)          conv_cnt <= '0;
    else if (eoc_out) conv_cnt <= '0;
    else              conv_cnt <= conv_cnt + 1'b1;
  end

`ifdef DRP_RESP_AVG_EN
  logic [2:0][11:0] hist;
  logic [13:0]      avg_sum;

  assign avg_sum = 14'(sample_in) + 14'(hist[0]) + 14'(hist[1]) + 14'(hist[2]);

  // Capture path with a four-deep history, averaged on each conversion.
  always_ff @(posedge clk) begin
    // NOTE: the history is only three words, so it is cleared on reset like
    // ordinary flops; large RAM-style arrays would not be reset this way.
    if (rst) begin
      hist       <= '0;
      sample_reg <= '0;
    end else if (eoc_out) begin
      hist       <= {hist[1], hist[0], sample_in};
      sample_reg <= avg_sum[13:2];
    end
  end
`else
  // Direct capture path: the raw sample is taken on each conversion.
  always_ff @(posedge clk) begin
    if (rst)          sample_reg <= '0;
    else if (eoc_out) sample_reg <= sample_in;
  end
`endif

endmodule

// File: rtl/xadc_drp_responder.sv
// DRP slave answering each accepted request after LATENCY+1 cycles.
// Serves the sample register at CHAN_ADDR and a read/write CFG0 register;
// other addresses read as zero. Requests arriving while busy are dropped
// and flagged on the sticky overrun output.
// Optional feature macro: DRP_RESP_AVG_EN (sample averaging in drp_eoc_timer).
module xadc_drp_responder
  import drp_resp_pkg::*;
#(
  parameter int         LATENCY     = 4,
  parameter int         CONV_PERIOD = 26,
  parameter logic [6:0] CHAN_ADDR   = 7'h1E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              den_in,
  input  logic              dwe_in,
  input  logic [6:0]        daddr_in,
  input  logic [DATA_W-1:0] di_in,
  output logic [DATA_W-1:0] do_out,
  output logic              drdy_out,
  output logic              eoc_out,
  input  logic [11:0]       sample_in,
  output logic              overrun
);

  drp_state_e        state;
  logic [3:0]        lat_cnt;
  logic [6:0]        addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [11:0]       snap_q;
  logic [DATA_W-1:0] cfg0;
  logic [DATA_W-1:0] resp_data;
  logic [11:0]       sample_reg;

  drp_eoc_timer #(
    .CONV_PERIOD (CONV_PERIOD)
  ) u_eoc_timer (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .eoc_out    (eoc_out),
    .sample_reg (sample_reg)
  );

  // Read data for the latched request; writes always answer with zero.
  always_comb begin
    // NOTE: default first so every path assigns resp_data and no latch forms.
    resp_data = '0;
    if (!we_q) begin
      if (addr_q == CHAN_ADDR)      resp_data = {snap_q, 4'h0};
      else if (addr_q == CFG0_ADDR) resp_data = cfg0;
    end
  end

  // Request FSM with registered drdy/do outputs; the sample is snapshotted at
  // accept so a coinciding conversion cannot change an in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      snap_q   <= '0;
      cfg0     <= '0;
      drdy_out <= 1'b0;
      do_out   <= '0;
      overrun  <= 1'b0;
    end else begin
      drdy_out <= 1'b0;
      do_out   <= '0;
      case (state)
        ST_IDLE: begin
          if (den_in) begin
            state   <= ST_BUSY;
            addr_q  <= daddr_in;
            we_q    <= dwe_in;
            wdata_q <= di_in;
            snap_q  <= sample_reg;
            lat_cnt <= 4'(LATENCY - 1);
          end
        end
        ST_BUSY: begin
          if (den_in) overrun <= 1'b1;
          if (lat_cnt == '0) begin
            state    <= ST_RESP;
            drdy_out <= 1'b1;
            do_out   <= resp_data;
            if (we_q && addr_q == CFG0_ADDR) cfg0 <= wdata_q;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (den_in) overrun <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
